// File: rtl/aes_ctr_packer.sv
// aes_ctr_packer: gathers a byte stream into 128-bit blocks for aes_ctr.
// The first byte of a block lands in [127:120]. The last block of a message is
// padded with PAD_BYTE and carries a keep mask with one bit per valid lane.
module aes_ctr_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   din_i,
    input  logic         din_valid_i,
    input  logic         din_last_i,
    output logic         din_ready_o,
    output logic [127:0] dout_o,
    output logic [15:0]  dout_keep_o,
    output logic         dout_last_o,
    output logic         dout_valid_o,
    input  logic         dout_ready_i
);

    logic [127:0] acc;        // partially filled block; unused lanes hold PAD_BYTE
    logic [3:0]   cnt;        // next free lane
    logic [127:0] merged;     // accumulator with the incoming byte dropped into lane cnt
    logic [15:0]  keep_next;  // keep mask for a block completed at lane cnt
    logic         accept;
    logic         complete;

    // A held block blocks the input. A block that drains this cycle frees
    // the input in the same cycle, so the stream runs at full rate.
    assign din_ready_o = !dout_valid_o || dout_ready_i;
    assign accept      = din_valid_i && din_ready_o;
    assign complete    = accept && (din_last_i || cnt == 4'd15);

    // Place the incoming byte in its lane and build the keep mask for this lane count
    always_comb begin
        // NOTE: every always_comb output gets a default first. A path that does
        // not assign the output would otherwise infer a latch.
        merged    = acc;
        keep_next = ~(16'hFFFF >> ({1'b0, cnt} + 5'd1));
        for (int k = 0; k < 16; k++) begin
            if (cnt == 4'(k)) begin
                merged[127 - 8*k -: 8] = din_i;
            end
        end
    end

    // Accumulator and lane counter: fill one lane at a time, then restart empty
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulator is a data register, yet it must be reset. The
        // padding of a short final block depends on the untouched lanes already
        // holding PAD_BYTE.
        if (!rst_n) begin
            acc <= {16{PAD_BYTE}};
            cnt <= 4'd0;
        end else if (complete) begin
            // NOTE: state uses non-blocking assignments. The completing edge reads
            // the old acc/cnt through merged/keep_next while they are cleared here.
            acc <= {16{PAD_BYTE}};
            cnt <= 4'd0;
        end else if (accept) begin
            acc <= merged;
            cnt <= cnt + 4'd1;
        end
    end

    // Output register: load on a completing byte, clear the flags when a block is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_o       <= '0;
            dout_keep_o  <= '0;
            dout_last_o  <= 1'b0;
            dout_valid_o <= 1'b0;
        end else if (complete) begin
            dout_o       <= merged;
            dout_keep_o  <= keep_next;
            dout_last_o  <= din_last_i;
            dout_valid_o <= 1'b1;
        end else if (dout_valid_o && dout_ready_i) begin
            dout_keep_o  <= '0;
            dout_last_o  <= 1'b0;
            dout_valid_o <= 1'b0;
        end
    end

endmodule
